// File: rtl/ship_missile.sv
// Player missile: edge-triggered fire launches one missile from the ship's top-centre and moves it up each frame.
// Spawns one edge after fire; a hit or off-screen starts COOLDOWN_FRAMES of re-arm. Build with MISSILE_AUTOFIRE_EN for a level-sensitive fire key.
module ship_missile #(
  parameter logic [7:0] FIRE_KEY        = 8'h2C,
  parameter logic [9:0] MISSILE_STEP    = 10'd6,
  parameter logic [9:0] MISSILE_SX      = 10'd2,
  parameter logic [9:0] MISSILE_SY      = 10'd8,
  parameter logic [5:0] COOLDOWN_FRAMES = 6'd15
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic [7:0] keycode,
  input  logic [9:0] ShipX,
  input  logic [9:0] ShipY,
  input  logic [9:0] ShipSX,
  input  logic       hit,
  output logic [9:0] MissileX,
  output logic [9:0] MissileY,
  output logic [9:0] MissileSX,
  output logic [9:0] MissileSY,
  output logic       missile_active,
  output logic [7:0] shots_fired
);

  typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} state_t;

  state_t     state, state_nxt;
  logic [9:0] missile_x, missile_x_nxt;
  logic [9:0] missile_y, missile_y_nxt;
  logic [5:0] cool_cnt, cool_cnt_nxt;
  logic [7:0] shot_cnt, shot_cnt_nxt;
  logic       key_prev;
  logic       fire_key;
  logic       fire_req;

  assign fire_key = (keycode == FIRE_KEY);

`ifdef MISSILE_AUTOFIRE_EN
  assign fire_req = fire_key;
`else
  assign fire_req = fire_key && !key_prev;
`endif

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      missile_x <= '0;
      missile_y <= '0;
      cool_cnt  <= '0;
      shot_cnt  <= '0;
      key_prev  <= 1'b0;
    end else begin
      state     <= state_nxt;
      missile_x <= missile_x_nxt;
      missile_y <= missile_y_nxt;
      cool_cnt  <= cool_cnt_nxt;
      shot_cnt  <= shot_cnt_nxt;
      key_prev  <= fire_key;
    end
  end

  always_comb begin
    state_nxt     = state;
    missile_x_nxt = missile_x;
    missile_y_nxt = missile_y;
    cool_cnt_nxt  = cool_cnt;
    shot_cnt_nxt  = shot_cnt;
    case (state)
      IDLE: begin
        if (fire_req) begin
          state_nxt     = FLYING;
          missile_x_nxt = ShipX + (ShipSX >> 1);
          missile_y_nxt = (ShipY >= MISSILE_SY) ? ShipY - MISSILE_SY : 10'd0;
          shot_cnt_nxt  = shot_cnt + 8'd1;
        end
      end
      FLYING: begin
        // A hit and leaving the top share one exit; position freezes on that edge
        if (hit || (missile_y < MISSILE_STEP)) begin
          state_nxt    = COOLDOWN;
          cool_cnt_nxt = COOLDOWN_FRAMES - 6'd1;
        end else begin
          missile_y_nxt = missile_y - MISSILE_STEP;
        end
      end
      COOLDOWN: begin
        if (cool_cnt == 6'd0) state_nxt = IDLE;
        else                  cool_cnt_nxt = cool_cnt - 6'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign MissileX       = missile_x;
  assign MissileY       = missile_y;
  assign MissileSX      = MISSILE_SX;
  assign MissileSY      = MISSILE_SY;
  assign missile_active = (state == FLYING);
  assign shots_fired    = shot_cnt;

endmodule

// File: tb/tb_ship_missile.sv
// Bench for ship_missile: vector table, hand-written corner sequences, then random stimulus against a frame-level model.
module tb_ship_missile;

  logic       frame_clk = 1'b0;
  logic       Reset_n;
  logic [7:0] keycode;
  logic [9:0] ShipX, ShipY, ShipSX;
  logic       hit;
  logic [9:0] MissileX, MissileY, MissileSX, MissileSY;
  logic       missile_active;
  logic [7:0] shots_fired;

  ship_missile dut (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .keycode(keycode),
    .ShipX(ShipX), .ShipY(ShipY), .ShipSX(ShipSX), .hit(hit),
    .MissileX(MissileX), .MissileY(MissileY), .MissileSX(MissileSX), .MissileSY(MissileSY),
    .missile_active(missile_active), .shots_fired(shots_fired)
  );

  always #5 frame_clk = ~frame_clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int x, input int y, input logic act, input int shots);
    chk({tag, ".x"}, {22'd0, MissileX}, x);
    chk({tag, ".y"}, {22'd0, MissileY}, y);
    chk({tag, ".act"}, {31'd0, missile_active}, {31'd0, act});
    chk({tag, ".shots"}, {24'd0, shots_fired}, shots);
  endtask

  // Frame-level reference: a missile is either in the air, counting down frames, or ready.
  bit m_act, m_prev;
  int m_x, m_y, m_cool, m_shots;

  task automatic model_reset();
    m_act = 0; m_prev = 0; m_x = 0; m_y = 0; m_cool = 0; m_shots = 0;
  endtask

  task automatic model_edge(input logic [7:0] k, input logic h, input int sx, input int sy, input int ssx);
    bit key, fire;
    key = (k == 8'h2C);
`ifdef MISSILE_AUTOFIRE_EN
    fire = key;
`else
    fire = key && !m_prev;
`endif
    if (m_act) begin
      if (h || m_y < 6) begin
        m_act  = 0;
        m_cool = 15;
      end else begin
        m_y = m_y - 6;
      end
    end else if (m_cool > 0) begin
      m_cool = m_cool - 1;
    end else if (fire) begin
      m_act   = 1;
      m_x     = (sx + ssx / 2) % 1024;
      m_y     = (sy >= 8) ? sy - 8 : 0;
      m_shots = (m_shots + 1) % 256;
    end
    m_prev = key;
  endtask

  typedef struct {
    logic [7:0] key;
    logic       hit;
    int         x;
    int         y;
    logic       act;
    int         shots;
  } vec_t;

  vec_t tbl[23];

  initial begin
    // Launch, four moves, hit on the fifth edge, 15 cooldown edges with stray presses, relaunch
    tbl[0] = '{8'h2C, 1'b0, 332, 432, 1'b1, 1};
    tbl[1] = '{8'h2C, 1'b0, 332, 426, 1'b1, 1};
    tbl[2] = '{8'h00, 1'b0, 332, 420, 1'b1, 1};
    tbl[3] = '{8'h2C, 1'b0, 332, 414, 1'b1, 1};
    tbl[4] = '{8'h00, 1'b0, 332, 408, 1'b1, 1};
    tbl[5] = '{8'h2C, 1'b1, 332, 408, 1'b0, 1};
    for (int i = 6; i <= 20; i++)
      tbl[i] = '{((i % 2) == 1) ? 8'h2C : 8'h00, 1'b0, 332, 408, 1'b0, 1};
    tbl[21] = '{8'h00, 1'b0, 332, 408, 1'b0, 1};
    tbl[22] = '{8'h2C, 1'b0, 332, 432, 1'b1, 2};

    Reset_n = 1'b0;
    keycode = 8'h2C;
    hit     = 1'b0;
    ShipX   = 10'd320;
    ShipY   = 10'd440;
    ShipSX  = 10'd25;
    tick();
    tick();
    chk_out("reset", 0, 0, 1'b0, 0);
    chk("reset.sx", {22'd0, MissileSX}, 2);
    chk("reset.sy", {22'd0, MissileSY}, 8);
    Reset_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      keycode = tbl[i].key;
      hit     = tbl[i].hit;
      tick();
      chk_out($sformatf("tbl%0d", i), tbl[i].x, tbl[i].y, tbl[i].act, tbl[i].shots);
    end

    // Off-screen: 72 moves from 432 reach 0, next edge ends flight, 15 cooldown edges follow
    keycode = 8'h00;
    hit     = 1'b0;
    for (int i = 0; i < 72; i++) tick();
    chk_out("top", 332, 0, 1'b1, 2);
    tick();
    chk_out("offscreen", 332, 0, 1'b0, 2);
    for (int i = 0; i < 15; i++) tick();
    chk_out("cool_end", 332, 0, 1'b0, 2);
    keycode = 8'h2C;
    tick();
    chk_out("rearm", 332, 432, 1'b1, 3);

    // Asynchronous reset mid-flight
    keycode = 8'h00;
    tick();
    tick();
    #2 Reset_n = 1'b0;
    #1 chk_out("async_rst", 0, 0, 1'b0, 0);
    keycode = 8'h2C;
    ShipX   = 10'd1020;
    ShipY   = 10'd5;
    ShipSX  = 10'd10;
    tick();
    chk_out("rst_hold", 0, 0, 1'b0, 0);
    Reset_n = 1'b1;
    tick();
    chk_out("clamp_wrap", 1, 0, 1'b1, 1);

    // Held key through flight and cooldown, with hit and off-screen on the same edge
    hit = 1'b1;
    tick();
    chk_out("hit_top", 1, 0, 1'b0, 1);
    hit = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk_out("held_cool", 1, 0, 1'b0, 1);
    tick();
`ifdef MISSILE_AUTOFIRE_EN
    chk_out("held_idle", 1, 0, 1'b1, 2);
`else
    chk_out("held_idle", 1, 0, 1'b0, 1);
`endif
    keycode = 8'h00;
    tick();
    keycode = 8'h2C;
    tick();
    chk("repress.shots", {24'd0, shots_fired}, 2);

    // 256 launches wrap the shot counter
    Reset_n = 1'b0;
    #2 Reset_n = 1'b1;
    ShipX = 10'd100; ShipY = 10'd200; ShipSX = 10'd8;
    for (int n = 1; n <= 256; n++) begin
      keycode = 8'h2C; hit = 1'b0;
      tick();
      keycode = 8'h00; hit = 1'b1;
      tick();
      hit = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      if (n == 255) chk("wrap255", {24'd0, shots_fired}, 255);
    end
    chk("wrap0", {24'd0, shots_fired}, 0);

    // Random stimulus against the model
    Reset_n = 1'b0;
    #2 Reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    keycode = 8'h2C;
        2:       keycode = 8'h00;
        default: keycode = 8'($urandom_range(0, 255));
      endcase
      hit    = ($urandom_range(0, 7) == 0);
      ShipX  = 10'($urandom_range(0, 1023));
      ShipY  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 12)) : 10'($urandom_range(0, 1023));
      ShipSX = 10'($urandom_range(0, 1023));
      model_edge(keycode, hit, int'(ShipX), int'(ShipY), int'(ShipSX));
      tick();
      chk_out($sformatf("rnd%0d", i), m_x, m_y, m_act, m_shots);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
